// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Brief    : Shares one data-memory port between operand-fetch reads and
//            write-back stores; write priority bounded by a starvation count.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int DDATAW = 64,
    parameter int DSIZEW = 4,
    parameter int DADDRW = 32,
    parameter int STARVE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DADDRW-1:0] r_address,
    output logic              r_dp_valid,
    input  logic              r_dp_ready,
    output logic [DDATAW-1:0] r_dp_read_data,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DADDRW-1:0] w_address,
    input  logic [DDATAW-1:0] w_wr_data,
    input  logic [DSIZEW-1:0] w_wr_size,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DADDRW-1:0] m_address,
    output logic              m_wr_en,
    output logic [DDATAW-1:0] m_wr_data,
    output logic [DSIZEW-1:0] m_wr_size,
    input  logic              m_dp_valid,
    output logic              m_dp_ready,
    input  logic [DDATAW-1:0] m_dp_read_data
);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_rd_addr = 3'd1;
    localparam logic [2:0] c_rd_data = 3'd2;
    localparam logic [2:0] c_drain   = 3'd3;
    localparam logic [2:0] c_wr_addr = 3'd4;

    localparam logic [2:0] c_starve  = 3'(STARVE);

    logic [2:0] r_state;
    logic [2:0] r_starve_cnt;

    logic w_rq;
    logic w_grant_wr;

    assign w_rq       = r_valid & ~flush;
    // A write may jump a waiting read only until the read has been passed over STARVE times.
    assign w_grant_wr = w_valid & (~w_rq | (r_starve_cnt < c_starve));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_idle;
            r_starve_cnt <= 3'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_grant_wr) begin
                        r_state <= c_wr_addr;
                        if (w_rq && (r_starve_cnt != c_starve)) begin
                            r_starve_cnt <= r_starve_cnt + 3'd1;
                        end
                    end else if (w_rq) begin
                        r_state      <= c_rd_addr;
                        r_starve_cnt <= 3'd0;
                    end
                end
                c_wr_addr: begin
                    if (!w_valid || m_ready) begin
                        r_state <= c_idle;
                    end
                end
                c_rd_addr: begin
                    if (flush || !r_valid) begin
                        r_state <= c_idle;
                    end else if (m_ready) begin
                        r_state <= c_rd_data;
                    end
                end
                c_rd_data: begin
                    if (m_dp_valid && (r_dp_ready || flush)) begin
                        r_state <= c_idle;
                    end else if (flush) begin
                        r_state <= c_drain;
                    end
                end
                c_drain: begin
                    if (m_dp_valid) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign r_dp_read_data = m_dp_read_data;

    always_comb begin
        r_ready    = 1'b0;
        w_ready    = 1'b0;
        r_dp_valid = 1'b0;
        m_valid    = 1'b0;
        m_address  = '0;
        m_wr_en    = 1'b0;
        m_wr_data  = '0;
        m_wr_size  = '0;
        m_dp_ready = 1'b0;
        case (r_state)
            c_wr_addr: begin
                m_valid   = w_valid;
                m_wr_en   = 1'b1;
                m_address = w_address;
                m_wr_data = w_wr_data;
                m_wr_size = w_wr_size;
                w_ready   = m_ready;
            end
            c_rd_addr: begin
                m_valid   = r_valid & ~flush;
                m_address = r_address;
                r_ready   = m_ready & ~flush;
            end
            c_rd_data: begin
                r_dp_valid = m_dp_valid & ~flush;
                m_dp_ready = r_dp_ready | flush;
            end
            c_drain: begin
                m_dp_ready = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Brief    : Directed stimulus with queued expectations for dmem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        r_valid, r_ready, r_dp_valid, r_dp_ready;
    logic [31:0] r_address;
    logic [63:0] r_dp_read_data;
    logic        w_valid, w_ready;
    logic [31:0] w_address;
    logic [63:0] w_wr_data;
    logic [3:0]  w_wr_size;
    logic        m_valid, m_ready, m_wr_en, m_dp_valid, m_dp_ready;
    logic [31:0] m_address;
    logic [63:0] m_wr_data, m_dp_read_data;
    logic [3:0]  m_wr_size;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [63:0] data;
        logic [3:0]  size;
    } mtx_t;

    mtx_t        exp_m[$];
    logic [63:0] exp_rd[$];
    int          checks   = 0;
    int          failures = 0;

    dmem_port_arbiter #(.DDATAW(64), .DSIZEW(4), .DADDRW(32), .STARVE(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .r_valid(r_valid), .r_ready(r_ready), .r_address(r_address),
        .r_dp_valid(r_dp_valid), .r_dp_ready(r_dp_ready), .r_dp_read_data(r_dp_read_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_address(w_address),
        .w_wr_data(w_wr_data), .w_wr_size(w_wr_size),
        .m_valid(m_valid), .m_ready(m_ready), .m_address(m_address), .m_wr_en(m_wr_en),
        .m_wr_data(m_wr_data), .m_wr_size(m_wr_size),
        .m_dp_valid(m_dp_valid), .m_dp_ready(m_dp_ready), .m_dp_read_data(m_dp_read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation at every accepted address phase / read beat.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid && m_ready) begin
                if (exp_m.size() == 0) begin
                    chk("unexpected_addr_phase", {m_wr_en, m_address}, 33'h0);
                end else begin
                    mtx_t e;
                    e = exp_m.pop_front();
                    if (e.wr)
                        chk("addr_phase_wr", {m_wr_en, m_address, m_wr_data, m_wr_size}, e);
                    else
                        chk("addr_phase_rd", {m_wr_en, m_address}, {e.wr, e.addr});
                end
            end
            if (r_dp_valid && r_dp_ready) begin
                if (exp_rd.size() == 0) begin
                    chk("unexpected_read_beat", r_dp_read_data, 64'h0);
                end else begin
                    chk("read_data", r_dp_read_data, exp_rd.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0;
        r_valid = 1'b0; r_address = '0; r_dp_ready = 1'b1;
        w_valid = 1'b0; w_address = '0; w_wr_data = '0; w_wr_size = '0;
        m_ready = 1'b0; m_dp_valid = 1'b0; m_dp_read_data = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset_outputs", {m_valid, r_ready, w_ready, r_dp_valid, m_dp_ready, m_wr_en, m_address}, '0);

        // Lone read
        r_valid = 1'b1; r_address = 32'h1000; m_ready = 1'b1;
        exp_m.push_back('{wr: 1'b0, addr: 32'h1000, data: '0, size: '0});
        #1;
        chk("rd_idle_no_valid", m_valid, 1'b0);
        tick();
        chk("rd_addr_valid", {m_valid, r_ready, m_wr_en}, 3'b110);
        tick();
        r_valid = 1'b0;
        m_dp_valid = 1'b1; m_dp_read_data = 64'hDEADBEEF_CAFEF00D;
        exp_rd.push_back(64'hDEADBEEF_CAFEF00D);
        #1;
        chk("rd_data_valid", {m_valid, r_dp_valid, m_dp_ready}, 3'b011);
        tick();
        m_dp_valid = 1'b0;
        #1;
        chk("rd_back_idle", {r_dp_valid, m_dp_ready, m_valid}, 3'b000);

        // Lone write, w_ready follows m_ready
        m_ready = 1'b0;
        w_valid = 1'b1; w_address = 32'h2000; w_wr_data = 64'h55; w_wr_size = 4'd1;
        tick();
        chk("wr_addr_stall", {m_valid, m_wr_en, w_ready, m_address}, {3'b110, 32'h2000});
        m_ready = 1'b1;
        exp_m.push_back('{wr: 1'b1, addr: 32'h2000, data: 64'h55, size: 4'd1});
        #1;
        chk("wr_ready_mirror", w_ready, 1'b1);
        tick();
        w_valid = 1'b0;
        #1;
        chk("wr_back_idle", {m_valid, w_ready}, 2'b00);

        // Continuous competing requests: W,W,W,W,R repeated
        w_valid = 1'b1; w_address = 32'h3000; w_wr_data = 64'hAA; w_wr_size = 4'd2;
        r_valid = 1'b1; r_address = 32'h4000;
        for (int g = 0; g < 10; g++) begin
            logic is_rd;
            is_rd = ((g % 5) == 4);
            if (is_rd) exp_m.push_back('{wr: 1'b0, addr: 32'h4000, data: '0, size: '0});
            else       exp_m.push_back('{wr: 1'b1, addr: 32'h3000, data: 64'hAA, size: 4'd2});
            tick();
            chk("grant_order", {m_valid, m_wr_en}, {1'b1, ~is_rd});
            tick();
            if (is_rd) begin
                m_dp_valid = 1'b1; m_dp_read_data = 64'h100 + 64'(g);
                exp_rd.push_back(64'h100 + 64'(g));
                tick();
                m_dp_valid = 1'b0;
            end
        end
        w_valid = 1'b0; r_valid = 1'b0;
        tick();

        // Flush in RD_ADDR with memory ready
        r_valid = 1'b1; r_address = 32'h5000; m_ready = 1'b1;
        tick();
        flush = 1'b1;
        #1;
        chk("flush_rd_addr", {m_valid, r_ready}, 2'b00);
        tick();
        flush = 1'b0; r_valid = 1'b0;
        tick();
        chk("flush_rd_addr_idle", m_valid, 1'b0);

        // Flush in RD_DATA, late data drained, pending write then granted
        r_valid = 1'b1; r_address = 32'h6000;
        exp_m.push_back('{wr: 1'b0, addr: 32'h6000, data: '0, size: '0});
        tick();
        tick();
        r_valid = 1'b0;
        w_valid = 1'b1; w_address = 32'h7000; w_wr_data = 64'h77; w_wr_size = 4'd3;
        flush = 1'b1;
        #1;
        chk("flush_rd_data", {m_dp_ready, r_dp_valid, m_valid}, 3'b100);
        tick();
        flush = 1'b0;
        #1;
        chk("drain_hold", {m_dp_ready, m_valid}, 2'b10);
        tick();
        chk("drain_hold2", {m_dp_ready, m_valid}, 2'b10);
        tick();
        m_dp_valid = 1'b1; m_dp_read_data = 64'hBAD;
        #1;
        chk("drain_discard", {m_dp_ready, r_dp_valid, m_valid}, 3'b100);
        tick();
        m_dp_valid = 1'b0;
        exp_m.push_back('{wr: 1'b1, addr: 32'h7000, data: 64'h77, size: 4'd3});
        #1;
        chk("drain_exit_idle", {m_valid, m_dp_ready}, 2'b00);
        tick();
        chk("pending_wr_grant", {m_valid, m_wr_en}, 2'b11);
        tick();
        w_valid = 1'b0;

        // Reset while waiting for read data
        r_valid = 1'b1; r_address = 32'h8000;
        exp_m.push_back('{wr: 1'b0, addr: 32'h8000, data: '0, size: '0});
        tick();
        tick();
        r_valid = 1'b0;
        #1;
        chk("pre_reset_rd_data", m_dp_ready, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("reset_mid_read", {m_valid, r_ready, w_ready, r_dp_valid, m_dp_ready, m_wr_en, m_address}, '0);

        tick(); tick();
        chk("addr_queue_empty", 128'(exp_m.size()), 128'd0);
        chk("data_queue_empty", 128'(exp_rd.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
